fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined processor.
//  - Owns the PC and issues requests to a stalling, in-order instruction memory.
//  - Buffers returned instructions in a FIFO and presents them to decode over valid/ready.
//  - Handles redirects (branch/jump) by flushing the FIFO and discarding in-flight responses.
// PARAMETERS
//  ADDR_W     16  PC / instruction-memory address width
//  INST_W     16  instruction width
//  DEPTH       4  instruction FIFO entries; also the max outstanding requests (power of 2, >=2)
//  PC_INC      2  sequential PC increment in bytes
//  RESET_PC    0  PC value loaded at reset
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous, active-low reset
//  imem_req       out  1       request valid
//  imem_addr      out  ADDR_W  request address (current PC)
//  imem_busy      in   1       memory cannot accept; request held while high
//  imem_rvalid    in   1       response valid (in order, >=1 cycle after acceptance)
//  imem_rdata     in   INST_W  response instruction
//  redirect       in   1       load PC from redirect_pc, flush
//  redirect_pc    in   ADDR_W  redirect target
//  halt           in   1       stop issuing requests (sticky until reset)
//  inst_valid     out  1       decode entry valid
//  inst_data      out  INST_W  instruction
//  inst_pc        out  ADDR_W  address of inst_data
//  inst_pc_next   out  ADDR_W  inst_pc + PC_INC (for JAL/R7 writeback)
//  inst_ready     in   1       decode accepts entry
//  halted         out  1       halt seen, no requests outstanding, FIFO empty
//  err            out  1       error flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: PC=RESET_PC, FIFO empty, outstanding=0, drop=0, halt latch=0. All outputs 0
//    except imem_addr=RESET_PC.
//  - Issue rule: imem_req = !halt_latched && !redirect && (outstanding + count) < DEPTH.
//    Accepted when imem_req && !imem_busy; then PC += PC_INC (mod 2^ADDR_W), outstanding++.
//  - imem_addr must stay stable while imem_req && imem_busy.
//  - Response: imem_rvalid pushes {rdata, pc} into FIFO (pc from an in-order tag queue)
//    unless drop>0, in which case drop-- and the response is discarded. outstanding--.
//    A simultaneous accept and response leaves outstanding unchanged.
//  - Credit rule guarantees no overflow. An rvalid with outstanding==0 is ignored.
//  - Decode: head entry shown on inst_*; pop on inst_valid && inst_ready. Push and pop in
//    the same cycle are both honoured. Push to an empty FIFO is visible next cycle
//    (1-cycle min latency from rvalid to inst_valid).
//  - Redirect (highest priority): FIFO cleared and inst_valid=0 next cycle; PC<=redirect_pc;
//    drop<=outstanding minus any non-dropped response this cycle; no issue in this cycle.
//    Pop in the same cycle is ignored. Redirect while drop>0 accumulates.
//  - Halt: latched on halt=1. Issue stops next cycle. In-flight responses still complete.
//    halted=1 once outstanding==0, drop==0 and FIFO empty. Redirect does not clear halt.
//  - State: RUN (issuing), DRAIN (halt latched, outstanding>0 or FIFO non-empty),
//    HALTED. RUN->DRAIN on halt; DRAIN->HALTED on drain condition; exit only by reset.
//  - Async reset mid-operation: all state cleared immediately; outstanding memory
//    responses are never seen (memory is reset with the core).
// CONFIGURATION
//  FETCH_ERR_CHECK_EN defined:
//    err is a registered sticky flag, set by any of:
//    - redirect_pc[0]=1 (misaligned, when PC_INC=2)
//    - imem_rvalid with outstanding==0
//    - imem_addr changed while the request is held busy
//    It is cleared only by reset.
//  Not defined: err tied to 0; no checking logic is built.
// TESTING
//  1. Reset, zero-wait memory (rvalid 1 cycle after accept), inst_ready=1
//     -> inst_pc 0,2,4,6... back-to-back, one per cycle after 2-cycle fill.
//  2. inst_ready=0 for 10 cycles -> exactly DEPTH(4) entries buffered, imem_req=0.
//     On release, order 0,2,4,6 is preserved with no loss.
//  3. imem_busy=1 for 3 cycles at PC=8 -> imem_req=1 and imem_addr=8 held.
//     PC advances only on the cycle busy drops.
//  4. Two requests in flight (0x10,0x12), redirect to 0x40
//     -> both responses dropped, next inst_pc=0x40, no 0x10/0x12 delivered.
//  5. halt with 2 outstanding and 1 buffered -> no further imem_req.
//     halted=1 only after both responses arrive and 3 entries are popped.
//  6. FETCH_ERR_CHECK_EN: redirect to 0x0041 -> err=1 next cycle and stays 1.
//     Without the macro, err=0 throughout.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues credit-limited requests to in-order imem, buffers responses for decode.
// Optional macro FETCH_ERR_CHECK_EN builds the sticky err checker; otherwise err is tied low.
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16,
  parameter int DEPTH = 4,
  parameter int PC_INC = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_busy,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc_next,
  input  logic              inst_ready,
  output logic              halted,
  output logic              err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc [DEPTH];
  logic [ADDR_W-1:0] tag [DEPTH];
  logic [PW-1:0] wp, rp, tag_wp, tag_rp;
  logic [CW-1:0] count, outstanding, drop;
  logic accept, rsp, keep, push, pop, drained;
  assign imem_addr = pc;
  assign imem_req = rst_n && state == RUN && !redirect &&
                    ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);
  assign accept = imem_req && !imem_busy;
  assign rsp = imem_rvalid && outstanding != '0;
  assign keep = rsp && drop == '0;
  assign push = keep && !redirect;
  assign pop = inst_valid && inst_ready && !redirect;
  assign drained = outstanding == '0 && drop == '0 && count == '0;
  assign inst_valid = count != '0;
  assign inst_data = inst_valid ? fifo_data[rp] : '0;
  assign inst_pc = inst_valid ? fifo_pc[rp] : '0;
  assign inst_pc_next = inst_valid ? fifo_pc[rp] + ADDR_W'(PC_INC) : '0;
  assign halted = state == HALTED;
  always_comb begin
    state_nx = state;
    state_nx = state == RUN ? (halt ? DRAIN : RUN) : (drained ? HALTED : state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= RESET_PC;
      wp <= '0;
      rp <= '0;
      tag_wp <= '0;
      tag_rp <= '0;
      count <= '0;
      outstanding <= '0;
      drop <= '0;
    end else begin
      state <= state_nx;
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (accept) tag_wp <= tag_wp + PW'(1);
      if (rsp) tag_rp <= tag_rp + PW'(1);
      if (redirect) pc <= redirect_pc;
      else if (accept) pc <= pc + ADDR_W'(PC_INC);
      // every request still in flight at a redirect belongs to the old path
      if (redirect) drop <= outstanding - CW'(rsp);
      else if (rsp && drop != '0) drop <= drop - CW'(1);
      if (redirect) begin
        wp <= '0;
        rp <= '0;
        count <= '0;
      end else begin
        if (push) wp <= wp + PW'(1);
        if (pop) rp <= rp + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) tag[tag_wp] <= pc;
    if (push) begin
      fifo_data[wp] <= imem_rdata;
      fifo_pc[wp] <= tag[tag_rp];
    end
  end
`ifdef FETCH_ERR_CHECK_EN
  logic err_q, held_q, misalign;
  logic [ADDR_W-1:0] held_addr;
  assign misalign = PC_INC == 2 && redirect && redirect_pc[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      held_q <= 1'b0;
      held_addr <= '0;
    end else begin
      held_q <= imem_req && imem_busy;
      held_addr <= imem_addr;
      if (misalign || (imem_rvalid && outstanding == '0) || (held_q && imem_addr != held_addr))
        err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios against a simple imem model; decoded entries checked by a scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b1;
  logic imem_req, imem_busy, imem_rvalid, redirect, halt, inst_valid, inst_ready, halted, err;
  logic [15:0] imem_addr, imem_rdata, redirect_pc, inst_data, inst_pc, inst_pc_next;
  logic mem_stall;
  logic [15:0] pend[$], exp_q[$];
  logic [15:0] mon_e;
  int checks = 0, failures = 0, pops = 0, acc_cnt = 0;
  int n, fill, t, base;
`ifdef FETCH_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_busy(imem_busy),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_pc_next(inst_pc_next), .inst_ready(inst_ready), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // memory: accept seen at the negedge before the edge, answer in the following cycle
  always @(negedge clk)
    if (rst_n && imem_req && !imem_busy) begin
      pend.push_back(imem_addr);
      acc_cnt++;
    end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (rst_n && !mem_stall && pend.size() != 0) begin
        imem_rdata = inst_of(pend.pop_front());
        imem_rvalid = 1'b1;
      end
    end
  end

  always @(negedge clk)
    if (rst_n && inst_valid && inst_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%0h required=none", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", inst_pc, mon_e);
        chk("pop_data", inst_data, inst_of(mon_e));
        chk("pop_pc_next", inst_pc_next, mon_e + 16'd2);
      end
    end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic ready, input logic busy, input logic stall);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pend.delete();
    exp_q.delete();
    pops = 0;
    acc_cnt = 0;
    imem_rvalid = 1'b0;
    inst_ready = ready;
    imem_busy = busy;
    mem_stall = stall;
    redirect = 1'b0;
    halt = 1'b0;
    redirect_pc = '0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic push_stream(input logic [15:0] start, input int k);
    for (int i = 0; i < k; i++) exp_q.push_back(start + 16'(2 * i));
  endtask

  task automatic wait_pops(input int k, input string name);
    int w;
    w = 0;
    while (pops < k && w < 50) begin
      @(posedge clk);
      w++;
    end
    #2;
    chk(name, 32'(pops >= k), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_busy = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    mem_stall = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc_next", inst_pc_next, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    // 1: zero-wait streaming
    do_reset(1'b1, 1'b0, 1'b0);
    push_stream(16'h0, 40);
    fill = 0;
    @(negedge clk);
    while (!inst_valid && fill < 10) begin
      fill++;
      @(negedge clk);
    end
    chk("t1_fill", fill, 2);
    n = 0;
    repeat (8) begin
      n += int'(inst_valid);
      @(negedge clk);
    end
    chk("t1_b2b", n, 8);
    // 2: decode stall fills the buffer
    @(posedge clk);
    #2;
    inst_ready = 1'b0;
    cyc(10);
    @(negedge clk);
    chk("t2_req_off", imem_req, 0);
    chk("t2_valid", inst_valid, 1);
    chk("t2_buffered", acc_cnt - pops, 4);
    @(posedge clk);
    #2;
    inst_ready = 1'b1;
    base = pops;
    wait_pops(base + 6, "t2_release");
    // 3: busy hold at PC=8
    do_reset(1'b1, 1'b0, 1'b0);
    push_stream(16'h0, 60);
    t = 0;
    while (imem_addr != 16'h8 && t < 20) begin
      cyc(1);
      t++;
    end
    chk("t3_reach8", imem_addr, 16'h8);
    imem_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_req", imem_req, 1);
      chk("t3_hold_addr", imem_addr, 16'h8);
      @(posedge clk);
      #2;
    end
    imem_busy = 1'b0;
    @(negedge clk);
    chk("t3_pre_adv", imem_addr, 16'h8);
    @(posedge clk);
    #2;
    chk("t3_adv", imem_addr, 16'hA);
    cyc(5);
    chk("t3_err", err, 0);
    // 4: redirect with two requests in flight
    do_reset(1'b0, 1'b1, 1'b1);
    cyc(1);
    redirect = 1'b1;
    redirect_pc = 16'h10;
    cyc(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_pc10", imem_addr, 16'h10);
    @(posedge clk);
    #2;
    imem_busy = 1'b0;
    cyc(2);
    imem_busy = 1'b1;
    @(negedge clk);
    chk("t4_pc14", imem_addr, 16'h14);
    chk("t4_acc", acc_cnt, 2);
    @(posedge clk);
    #2;
    redirect = 1'b1;
    redirect_pc = 16'h40;
    push_stream(16'h40, 30);
    cyc(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_pc40", imem_addr, 16'h40);
    chk("t4_valid_off", inst_valid, 0);
    @(posedge clk);
    #2;
    mem_stall = 1'b0;
    imem_busy = 1'b0;
    inst_ready = 1'b1;
    wait_pops(4, "t4_pops");
    // 5: halt with 2 outstanding and 1 buffered
    do_reset(1'b0, 1'b1, 1'b0);
    cyc(1);
    imem_busy = 1'b0;
    cyc(1);
    imem_busy = 1'b1;
    cyc(3);
    mem_stall = 1'b1;
    imem_busy = 1'b0;
    cyc(2);
    imem_busy = 1'b1;
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    imem_busy = 1'b0;
    chk("t5_acc", acc_cnt, 3);
    repeat (3) begin
      @(negedge clk);
      chk("t5_req_off", imem_req, 0);
      @(posedge clk);
      #2;
    end
    mem_stall = 1'b0;
    cyc(4);
    @(negedge clk);
    chk("t5_valid", inst_valid, 1);
    chk("t5_halted_pre", halted, 0);
    @(posedge clk);
    #2;
    push_stream(16'h0, 3);
    inst_ready = 1'b1;
    wait_pops(3, "t5_pops");
    t = 0;
    while (!halted && t < 10) begin
      cyc(1);
      t++;
    end
    chk("t5_halted", halted, 1);
    chk("t5_pops_exact", pops, 3);
    redirect = 1'b1;
    redirect_pc = 16'h80;
    cyc(1);
    redirect = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("t5_still_halted", halted, 1);
    chk("t5_req_after_redirect", imem_req, 0);
    chk("t5_acc_final", acc_cnt, 3);
    // 6: misaligned redirect
    do_reset(1'b0, 1'b1, 1'b0);
    cyc(1);
    @(negedge clk);
    chk("t6_err_pre", err, 0);
    @(posedge clk);
    #2;
    redirect = 1'b1;
    redirect_pc = 16'h41;
    cyc(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("t6_err", err, 32'(ERR_EN));
    cyc(3);
    @(negedge clk);
    chk("t6_err_sticky", err, 32'(ERR_EN));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
